// File: rtl/lsu_pkg.sv
// lsu_pkg: RV32I load/store width codes, FSM state encodings and a request
// legality helper shared by load_store_unit and lsu_align.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_MRG  = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    // Stores only have signed-looking width codes; BU/HU exist for loads only.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: little-endian lane extraction with sign/zero extension for loads,
// and byte/halfword merge of store data into a read word for sub-word stores.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        lane_b     = word[{offset, 3'b000} +: 8];
        lane_h     = offset[1] ? word[31:16] : word[15:0];
        load_data  = word;
        store_word = wdata;
        case (funct3)
            F3_B: begin
                load_data  = {{24{lane_b[7]}}, lane_b};
                store_word = word;
                store_word[{offset, 3'b000} +: 8] = wdata[7:0];
            end
            F3_BU: load_data = {24'h0, lane_b};
            F3_H: begin
                load_data  = {{16{lane_h[15]}}, lane_h};
                store_word = offset[1] ? {wdata[15:0], word[15:0]}
                                       : {word[31:16], wdata[15:0]};
            end
            F3_HU: load_data = {16'h0, lane_h};
            default: begin
                load_data  = word;
                store_word = wdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I loads/stores onto a word-wide memory without byte enables;
// sub-word stores run as read-modify-write. Optional macro: LSU_MISALIGN_TRAP_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_DEPTH = 16,
    parameter int AW         = $clog2(DATA_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [AW-1:0]         mem_addr,
    output logic                  mem_rd_en,
    output logic                  mem_wr_en,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    logic [2:0]            state_q;
    logic                  we_q;
    logic [2:0]            f3_q;
    logic [1:0]            off_q;
    logic [AW-1:0]         waddr_q;
    logic [DATA_WIDTH-1:0] wbuf_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic [2:0]            eff_f3;
    logic [1:0]            eff_off;
    logic                  is_half;
    logic                  is_word;
    logic                  req_err;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] store_word;
    logic                  unused_addr_hi;

    // Addresses wrap modulo the memory size.
    assign unused_addr_hi = ^req_addr[31:AW+2];

    // Request decode: illegal codes fall back to word access, offsets are forced aligned.
    always_comb begin
        eff_f3  = f3_legal(req_we, req_funct3) ? req_funct3 : F3_W;
        is_half = (eff_f3 == F3_H) || (eff_f3 == F3_HU);
        is_word = (eff_f3 == F3_W);
        eff_off = req_addr[1:0];
        if (is_word) begin
            eff_off = 2'b00;
        end else if (is_half) begin
            eff_off[0] = 1'b0;
        end
`ifdef LSU_MISALIGN_TRAP_EN
        req_err = !f3_legal(req_we, req_funct3) ||
                  (is_half && req_addr[0]) ||
                  (is_word && (req_addr[1:0] != 2'b00));
`else
        req_err = 1'b0;
`endif
    end

    lsu_align u_align (
        .funct3     (f3_q),
        .offset     (off_q),
        .word       (mem_rdata),
        .wdata      (wbuf_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    logic err_q;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: datapath registers are reset as well, since they drive outputs that must read 0 after reset.
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            f3_q    <= F3_W;
            off_q   <= 2'b00;
            waddr_q <= '0;
            wbuf_q  <= '0;
            rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= eff_f3;
                        off_q   <= eff_off;
                        waddr_q <= req_addr[AW+1:2];
                        wbuf_q  <= req_wdata;
                        rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
                        err_q   <= req_err;
`endif
                        if (req_err) begin
                            state_q <= S_RESP;
                        end else if (req_we && is_word) begin
                            state_q <= S_WR;
                        end else begin
                            state_q <= S_RD;
                        end
                    end
                end
                S_RD:  state_q <= S_MRG;
                S_MRG: begin
                    // mem_rdata holds the word read in S_RD during this cycle only.
                    if (we_q) begin
                        wbuf_q  <= store_word;
                        state_q <= S_WR;
                    end else begin
                        rdata_q <= load_data;
                        state_q <= S_RESP;
                    end
                end
                S_WR:   state_q <= S_RESP;
                S_RESP: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign mem_rd_en  = (state_q == S_RD);
    assign mem_wr_en  = (state_q == S_WR);
    assign mem_addr   = waddr_q;
    assign mem_wdata  = wbuf_q;

`ifdef LSU_MISALIGN_TRAP_EN
    assign resp_err = err_q;
`else
    assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit against a behavioural
// word memory; expectations come from a byte-level reference memory model.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic          mem_wr_en;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    load_store_unit #(.DATA_WIDTH(32), .DATA_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_rd_en  (mem_rd_en),
        .mem_wr_en  (mem_wr_en),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return 32'hA5C3_0000 ^ (32'(i) * 32'h0101_0707);
    endfunction

    // Registered-read word memory standing in for ReadWriteMemory.
    logic [31:0] mem [DEPTH];
    logic        preload;
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
        end else begin
            if (mem_wr_en) mem[mem_addr] <= mem_wdata;
            if (mem_rd_en) mem_rdata <= mem[mem_addr];
        end
    end

    typedef struct {
        string         name;
        logic [31:0]   rdata;
        logic          err;
        int            lat;
        int            n_rd;
        int            n_wr;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] ref_mem [DEPTH];
    int          n_cmp;
    int          n_bad;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference behaviour of one request, updating ref_mem for stores.
    function automatic void model(input string name, input logic we, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output exp_t e);
        int          sz;
        logic        legal;
        logic [1:0]  off;
        logic [31:0] w;
        logic [31:0] sh;
        legal = we ? (f3 <= 3'd2) : ((f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5));
        sz    = !legal ? 4 : (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off   = addr[1:0];
        e.name  = name;
        e.addr  = addr[AW+1:2];
        e.err   = 1'b0;
        e.rdata = 32'h0;
        e.n_rd  = 0;
        e.n_wr  = 0;
        e.wdata = 32'h0;
        e.lat   = 0;
`ifdef LSU_MISALIGN_TRAP_EN
        if (!legal || (sz == 2 && off[0]) || (sz == 4 && off != 2'd0)) begin
            e.err = 1'b1;
            e.lat = 1;
            return;
        end
`endif
        if (sz == 2) off[0] = 1'b0;
        if (sz == 4) off = 2'd0;
        w = ref_mem[e.addr];
        if (!we) begin
            sh = w >> (8 * int'(off));
            case (sz)
                1:       e.rdata = f3[2] ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
                2:       e.rdata = f3[2] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
                default: e.rdata = w;
            endcase
            e.lat  = 3;
            e.n_rd = 1;
        end else begin
            for (int i = 0; i < sz; i++) w[8 * (int'(off) + i) +: 8] = wdata[8 * i +: 8];
            ref_mem[e.addr] = w;
            e.wdata = w;
            e.n_wr  = 1;
            e.n_rd  = (sz < 4) ? 1 : 0;
            e.lat   = (sz < 4) ? 4 : 2;
        end
    endfunction

    task automatic issue(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
        exp_t        e;
        exp_t        got;
        int          lat;
        int          n_rd;
        int          n_wr;
        int          both;
        int          bad_addr;
        logic [31:0] last_wdata;
        check({name, "/ready"}, {31'h0, req_ready}, 32'd1);
        model(name, we, f3, addr, wdata, e);
        sb_q.push_back(e);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        lat = 1; n_rd = 0; n_wr = 0; both = 0; bad_addr = 0; last_wdata = 32'h0;
        while (!resp_valid && lat < 20) begin
            if (mem_rd_en) n_rd++;
            if (mem_wr_en) begin
                n_wr++;
                last_wdata = mem_wdata;
            end
            if (mem_rd_en && mem_wr_en) both++;
            if ((mem_rd_en || mem_wr_en) && mem_addr != e.addr) bad_addr++;
            @(posedge clk); #1;
            lat++;
        end
        got = sb_q.pop_front();
        check({got.name, "/latency"}, 32'(lat), 32'(got.lat));
        check({got.name, "/rdata"}, resp_rdata, got.rdata);
        check({got.name, "/err"}, {31'h0, resp_err}, {31'h0, got.err});
        check({got.name, "/rd_strobes"}, 32'(n_rd), 32'(got.n_rd));
        check({got.name, "/wr_strobes"}, 32'(n_wr), 32'(got.n_wr));
        check({got.name, "/rd_wr_overlap"}, 32'(both), 32'd0);
        check({got.name, "/mem_addr"}, 32'(bad_addr), 32'd0);
        if (got.n_wr > 0) check({got.name, "/mem_wdata"}, last_wdata, got.wdata);
        @(posedge clk); #1;
        check({got.name, "/resp_pulse"}, {31'h0, resp_valid}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "/req_ready"}, {31'h0, req_ready}, 32'd1);
        check({tag, "/resp_valid"}, {31'h0, resp_valid}, 32'd0);
        check({tag, "/resp_rdata"}, resp_rdata, 32'h0);
        check({tag, "/resp_err"}, {31'h0, resp_err}, 32'd0);
        check({tag, "/mem_rd_en"}, {31'h0, mem_rd_en}, 32'd0);
        check({tag, "/mem_wr_en"}, {31'h0, mem_wr_en}, 32'd0);
        check({tag, "/mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "/mem_wdata"}, mem_wdata, 32'h0);
    endtask

    // SH whose read-modify-write is cut by reset while in MRG: no write may occur.
    task automatic reset_mid_store();
        check("rst_mrg/ready", {31'h0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = F3_H;
        req_addr   = 32'h0000_000C;
        req_wdata  = 32'h0000_BEEF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rst_mrg/rd_cycle", {30'h0, mem_rd_en, mem_wr_en}, 32'd2);
        @(posedge clk); #1;
        check("rst_mrg/mrg_cycle", {30'h0, mem_rd_en, mem_wr_en}, 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("rst_mrg");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_mrg/no_write", {31'h0, mem_wr_en}, 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        rst_n      = 1'b0;
        preload    = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'h0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        preload = 1'b0;
        rst_n   = 1'b1;
        @(posedge clk); #1;

        issue("sw_0c",   1'b1, F3_W,  32'h0000_000C, 32'h8899_AABB);
        issue("lb_0e",   1'b0, F3_B,  32'h0000_000E, 32'h0);
        issue("lbu_0e",  1'b0, F3_BU, 32'h0000_000E, 32'h0);
        issue("lh_0e",   1'b0, F3_H,  32'h0000_000E, 32'h0);
        issue("lhu_0e",  1'b0, F3_HU, 32'h0000_000E, 32'h0);
        issue("sb_0d",   1'b1, F3_B,  32'h0000_000D, 32'h0000_0012);
        issue("lw_0c",   1'b0, F3_W,  32'h0000_000C, 32'h0);
        issue("lw_0e",   1'b0, F3_W,  32'h0000_000E, 32'h0);
        issue("sh_03",   1'b1, F3_H,  32'h0000_0003, 32'h0000_7F01);
        issue("lw_00",   1'b0, F3_W,  32'h0000_0000, 32'h0);
        issue("ld_f3_3", 1'b0, 3'b011, 32'h0000_0010, 32'h0);
        issue("st_f3_4", 1'b1, 3'b100, 32'h0000_0014, 32'h1234_5678);
        issue("lw_14",   1'b0, F3_W,  32'h0000_0014, 32'h0);

        reset_mid_store();
        issue("lw_0c_after_rst", 1'b0, F3_W, 32'h0000_000C, 32'h0);

        issue("sw_wrap_40", 1'b1, F3_W, 32'h0000_0040, 32'hDEAD_BEEF);
        issue("lw_wrap_00", 1'b0, F3_W, 32'h0000_0000, 32'h0);

        for (int i = 0; i < 4; i++) issue("lb_lane", 1'b0, F3_B, 32'h0000_0018 + 32'(i), 32'h0);

        for (int n = 0; n < 40; n++) begin
            logic        we;
            logic [2:0]  f3;
            logic [31:0] a;
            we = 1'($urandom);
            f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom)
               : (we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5)));
            a  = $urandom;
            issue(we ? "rnd_st" : "rnd_ld", we, f3, a, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
